// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 core: an LFSR drives the core inputs, a MISR compacts
// the responses, and the final signature is compared against GOLDEN.
module c17_bist_ctrl #(
    parameter int unsigned N_PAT     = 31,
    parameter int unsigned RESP_LAT  = 0,
    parameter logic [4:0]  LFSR_SEED = 5'b00001,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start_i,
    input  logic [1:0]  resp_i,
    output logic [4:0]  pat_o,
    output logic        test_mode_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] sig_o
);

    localparam int unsigned CW = 10;
    localparam int unsigned VW = (RESP_LAT == 0) ? 1 : RESP_LAT;
    localparam logic [CW-1:0] PAT_LAST   = CW'(N_PAT - 1);
    localparam logic [CW-1:0] DRAIN_LAST = (RESP_LAT == 0) ? '0 : CW'(RESP_LAT - 1);
    localparam bit LAT0 = (RESP_LAT == 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_start_run;
    logic            w_cap;
    logic [4:0]      r_lfsr;
    logic [4:0]      w_lfsr_next;
    logic [15:0]     r_misr;
    logic [15:0]     w_misr_fold;
    logic [15:0]     w_misr_next;
    logic [CW-1:0]   r_cnt;
    logic [VW-1:0]   r_vld;
    logic [VW:0]     w_vld_cat;
    logic [4:0]      r_pat;
    logic            r_tm;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    assign w_lfsr_next = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
    assign w_vld_cat   = {r_vld, (r_state == S_RUN)};
    assign w_misr_fold = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                       ^ {14'b0, resp_i};

    // Capture strobe: the pattern's own cycle when combinational, else the delayed valid bit.
    always_comb begin
        w_cap       = LAT0 ? (r_state == S_RUN) : r_vld[VW-1];
        w_misr_next = w_cap ? w_misr_fold : r_misr;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_start_run = 1'b1;
                    w_next      = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == PAT_LAST) w_next = LAT0 ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs, all keyed off the upcoming state.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_lfsr <= LFSR_SEED;
            r_misr <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
            r_pat  <= '0;
            r_tm   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_start_run) begin
            r_lfsr <= LFSR_SEED;
            r_misr <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
            r_pat  <= LFSR_SEED;
            r_tm   <= 1'b1;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_misr <= w_misr_next;
            if (r_state == S_RUN) r_lfsr <= w_lfsr_next;
            if (r_state == S_RUN || r_state == S_DRAIN) r_vld <= w_vld_cat[VW-1:0];
            case (w_next)
                S_RUN: begin
                    if (r_state == S_RUN) begin
                        r_cnt <= r_cnt + CW'(1);
                        r_pat <= w_lfsr_next;
                    end
                end
                S_DRAIN: begin
                    if (r_state == S_RUN) r_cnt <= '0;
                    else                  r_cnt <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    if (r_state != S_DONE) begin
                        r_cnt  <= '0;
                        r_pat  <= '0;
                        r_tm   <= 1'b0;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_misr_next == GOLDEN);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pat_o       = r_pat;
    assign test_mode_o = r_tm;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign sig_o       = r_misr;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl: several parameterisations share one clock and reset.
module tb_c17_bist_ctrl;

    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    int errors = 0;
    int checks = 0;

    // Behavioural references derived from the c17 netlist and the LFSR/MISR polynomials.
    function automatic logic [4:0] lfsr_step(input logic [4:0] q);
        return {q[3:0], q[4] ^ q[2]};
    endfunction

    function automatic logic [1:0] c17(input logic [4:0] p);
        logic g10, g11, g16, g19, g22, g23;
        g10 = ~(p[0] & p[2]);
        g11 = ~(p[2] & p[3]);
        g16 = ~(p[1] & g11);
        g19 = ~(g11 & p[4]);
        g22 = ~(g10 & g16);
        g23 = ~(g16 & g19);
        return {g23, g22};
    endfunction

    function automatic logic [15:0] misr_fold(input logic [15:0] m, input logic [1:0] r);
        logic [15:0] x;
        x = {m[14:0], 1'b0};
        if (m[15]) x = x ^ 16'h1021;
        return x ^ {14'b0, r};
    endfunction

    // Default instance, responses tied low
    logic st_def; logic [4:0] pat_def; logic tm_def, busy_def, done_def, pass_def; logic [15:0] sig_def;
    logic [1:0] resp_def;
    assign resp_def = 2'b00;
    c17_bist_ctrl u_def (.CK(CK), .RST(RST), .start_i(st_def), .resp_i(resp_def), .pat_o(pat_def),
        .test_mode_o(tm_def), .busy_o(busy_def), .done_o(done_def), .pass_o(pass_def), .sig_o(sig_def));

    // N_PAT=2 with two golden values, responses tied to 01
    logic st_n2; logic [4:0] pat_n2; logic tm_n2, busy_n2, done_n2, pass_n2; logic [15:0] sig_n2;
    logic st_n2g; logic [4:0] pat_n2g; logic tm_n2g, busy_n2g, done_n2g, pass_n2g; logic [15:0] sig_n2g;
    logic [1:0] resp_one;
    assign resp_one = 2'b01;
    c17_bist_ctrl #(.N_PAT(2)) u_n2 (.CK(CK), .RST(RST), .start_i(st_n2), .resp_i(resp_one), .pat_o(pat_n2),
        .test_mode_o(tm_n2), .busy_o(busy_n2), .done_o(done_n2), .pass_o(pass_n2), .sig_o(sig_n2));
    c17_bist_ctrl #(.N_PAT(2), .GOLDEN(16'h0003)) u_n2g (.CK(CK), .RST(RST), .start_i(st_n2g),
        .resp_i(resp_one), .pat_o(pat_n2g), .test_mode_o(tm_n2g), .busy_o(busy_n2g),
        .done_o(done_n2g), .pass_o(pass_n2g), .sig_o(sig_n2g));

    // RESP_LAT=2 with a c17 model behind a two-stage delay
    logic st_lat; logic [4:0] pat_lat; logic tm_lat, busy_lat, done_lat, pass_lat; logic [15:0] sig_lat;
    logic [4:0] r_d1 = 5'h00, r_d2 = 5'h00;
    logic [1:0] resp_lat;
    always @(posedge CK) begin
        r_d1 <= pat_lat;
        r_d2 <= r_d1;
    end
    assign resp_lat = c17(r_d2);
    c17_bist_ctrl #(.RESP_LAT(2)) u_lat2 (.CK(CK), .RST(RST), .start_i(st_lat), .resp_i(resp_lat),
        .pat_o(pat_lat), .test_mode_o(tm_lat), .busy_o(busy_lat), .done_o(done_lat),
        .pass_o(pass_lat), .sig_o(sig_lat));

    // N_PAT=40 with a combinational c17 model
    logic st_n40; logic [4:0] pat_n40; logic tm_n40, busy_n40, done_n40, pass_n40; logic [15:0] sig_n40;
    logic [1:0] resp_n40;
    assign resp_n40 = c17(pat_n40);
    c17_bist_ctrl #(.N_PAT(40)) u_n40 (.CK(CK), .RST(RST), .start_i(st_n40), .resp_i(resp_n40),
        .pat_o(pat_n40), .test_mode_o(tm_n40), .busy_o(busy_n40), .done_o(done_n40),
        .pass_o(pass_n40), .sig_o(sig_n40));

    task automatic test_reset;
        logic seen;
        RST = 1'b1;
        st_def = 0; st_n2 = 0; st_n2g = 0; st_lat = 0; st_n40 = 0;
        repeat (3) @(posedge CK);
        #1;
        checks++;
        if ({tm_def, busy_def, done_def, pass_def, pat_def, sig_def} !== 25'h0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {tm_def, busy_def, done_def, pass_def, pat_def, sig_def});
        if ({tm_def, busy_def, done_def, pass_def, pat_def, sig_def} !== 25'h0) errors++;
        RST = 1'b0;
        @(posedge CK); #1;
        st_def = 1'b1;
        @(posedge CK); #1;
        st_def = 1'b0;
        repeat (4) @(posedge CK);
        #1;
        checks++;
        if (tm_def !== 1'b1 || pat_def !== 5'h12) begin
            errors++;
            $display("FAIL pre_reset_run: tm=%b pat=%h expected tm=1 pat=12", tm_def, pat_def);
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({tm_def, busy_def, done_def, pass_def, pat_def, sig_def} !== 25'h0) begin
            errors++;
            $display("FAIL midrun_reset: got %h expected 0",
                     {tm_def, busy_def, done_def, pass_def, pat_def, sig_def});
        end
        @(posedge CK); #1;
        RST = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CK); #1;
            if (done_def !== 1'b0 || busy_def !== 1'b0 || tm_def !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: activity seen=%b expected 0", seen);
        end
    endtask

    task automatic test_defaults;
        logic [4:0] exp_p;
        logic [4:0] tbl [6];
        tbl = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
        exp_p = 5'h01;
        st_def = 1'b1;
        @(posedge CK); #1;
        st_def = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            checks++;
            if (pat_def !== exp_p || tm_def !== 1'b1 || busy_def !== 1'b1 || done_def !== 1'b0) begin
                errors++;
                $display("FAIL def_run c%0d: pat=%h tm=%b busy=%b done=%b expected pat=%h tm=1 busy=1 done=0",
                         c, pat_def, tm_def, busy_def, done_def, exp_p);
            end
            if (c <= 6) begin
                checks++;
                if (pat_def !== tbl[c-1]) begin
                    errors++;
                    $display("FAIL def_table c%0d: pat=%h expected %h", c, pat_def, tbl[c-1]);
                end
            end
            exp_p = lfsr_step(exp_p);
            @(posedge CK); #1;
        end
        checks++;
        if (done_def !== 1'b1 || pass_def !== 1'b1 || sig_def !== 16'h0000 ||
            tm_def !== 1'b0 || busy_def !== 1'b0 || pat_def !== 5'h00) begin
            errors++;
            $display("FAIL def_done: done=%b pass=%b sig=%h tm=%b busy=%b pat=%h expected 1 1 0000 0 0 00",
                     done_def, pass_def, sig_def, tm_def, busy_def, pat_def);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_p;
        exp_p = 5'h01;
        st_def = 1'b1;
        @(posedge CK); #1;
        st_def = 1'b0;
        checks++;
        if (done_def !== 1'b0 || pass_def !== 1'b0 || pat_def !== 5'h01) begin
            errors++;
            $display("FAIL restart: done=%b pass=%b pat=%h expected 0 0 01", done_def, pass_def, pat_def);
        end
        for (int c = 1; c <= 31; c++) begin
            checks++;
            if (pat_def !== exp_p || done_def !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run c%0d: pat=%h done=%b expected pat=%h done=0", c, pat_def, done_def, exp_p);
            end
            st_def = (c == 3 || c == 10);
            exp_p = lfsr_step(exp_p);
            @(posedge CK); #1;
        end
        st_def = 1'b0;
        checks++;
        if (done_def !== 1'b1 || sig_def !== 16'h0000) begin
            errors++;
            $display("FAIL b2b_done: done=%b sig=%h expected 1 0000", done_def, sig_def);
        end
    endtask

    task automatic test_n2;
        st_n2 = 1'b1; st_n2g = 1'b1;
        @(posedge CK); #1;
        st_n2 = 1'b0; st_n2g = 1'b0;
        @(posedge CK); #1;
        checks++;
        if (pat_n2 !== 5'h02 || done_n2 !== 1'b0) begin
            errors++;
            $display("FAIL n2_c2: pat=%h done=%b expected 02 0", pat_n2, done_n2);
        end
        @(posedge CK); #1;
        checks++;
        if (done_n2 !== 1'b1 || sig_n2 !== 16'h0003 || pass_n2 !== 1'b0) begin
            errors++;
            $display("FAIL n2_done: done=%b sig=%h pass=%b expected 1 0003 0", done_n2, sig_n2, pass_n2);
        end
        checks++;
        if (done_n2g !== 1'b1 || sig_n2g !== 16'h0003 || pass_n2g !== 1'b1) begin
            errors++;
            $display("FAIL n2g_done: done=%b sig=%h pass=%b expected 1 0003 1", done_n2g, sig_n2g, pass_n2g);
        end
    endtask

    task automatic test_resp_latency;
        logic [15:0] ref_m;
        logic [4:0]  p, last_p, exp_p;
        ref_m = 16'h0000;
        p = 5'h01;
        last_p = 5'h00;
        for (int i = 0; i < 31; i++) begin
            ref_m = misr_fold(ref_m, c17(p));
            last_p = p;
            p = lfsr_step(p);
        end
        exp_p = 5'h01;
        st_lat = 1'b1;
        @(posedge CK); #1;
        st_lat = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            checks++;
            if (pat_lat !== exp_p || tm_lat !== 1'b1) begin
                errors++;
                $display("FAIL lat_run c%0d: pat=%h tm=%b expected %h 1", c, pat_lat, tm_lat, exp_p);
            end
            exp_p = lfsr_step(exp_p);
            @(posedge CK); #1;
        end
        for (int c = 32; c <= 33; c++) begin
            checks++;
            if (tm_lat !== 1'b1 || busy_lat !== 1'b1 || done_lat !== 1'b0 || pat_lat !== last_p) begin
                errors++;
                $display("FAIL lat_drain c%0d: tm=%b busy=%b done=%b pat=%h expected 1 1 0 %h",
                         c, tm_lat, busy_lat, done_lat, pat_lat, last_p);
            end
            @(posedge CK); #1;
        end
        checks++;
        if (done_lat !== 1'b1 || sig_lat !== ref_m || pass_lat !== (ref_m == 16'h0000) || tm_lat !== 1'b0) begin
            errors++;
            $display("FAIL lat_done: done=%b sig=%h pass=%b tm=%b expected 1 %h %b 0",
                     done_lat, sig_lat, pass_lat, tm_lat, ref_m, (ref_m == 16'h0000));
        end
    endtask

    task automatic test_wrap;
        logic [15:0] ref_m;
        logic [4:0]  p, exp_p;
        logic        early;
        ref_m = 16'h0000;
        p = 5'h01;
        for (int i = 0; i < 40; i++) begin
            ref_m = misr_fold(ref_m, c17(p));
            p = lfsr_step(p);
        end
        exp_p = 5'h01;
        early = 1'b0;
        st_n40 = 1'b1;
        @(posedge CK); #1;
        st_n40 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if (pat_n40 !== exp_p) begin
                errors++;
                $display("FAIL wrap_run c%0d: pat=%h expected %h", c, pat_n40, exp_p);
            end
            if (c == 32) begin
                checks++;
                if (pat_n40 !== 5'h01) begin
                    errors++;
                    $display("FAIL wrap_index32: pat=%h expected 01", pat_n40);
                end
            end
            if (done_n40 !== 1'b0) early = 1'b1;
            exp_p = lfsr_step(exp_p);
            @(posedge CK); #1;
        end
        checks++;
        if (early !== 1'b0 || done_n40 !== 1'b1 || sig_n40 !== ref_m) begin
            errors++;
            $display("FAIL wrap_done: early=%b done=%b sig=%h expected 0 1 %h", early, done_n40, sig_n40, ref_m);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_back_to_back();
        test_n2();
        test_resp_latency();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
- Built-in self-test sequencer for the c17 gate-level core: 5 primary inputs (G1gat, G2gat, G3gat, G6gat, G7gat) and 2 outputs (G22gat, G23gat).
- Takes over the core inputs in test mode and drives them from a maximal-length LFSR.
- Compacts the core responses into a MISR and compares the final signature against a golden value.
- Sits beside the core; a top-level mux uses test_mode_o to select between functional inputs and pat_o.

Parameters:
- N_PAT, 31, patterns applied per run; range 1..1023.
- RESP_LAT, 0, cycles from pat_o to the matching response on resp_i; range 0..3. Use 0 for a purely combinational core.
- LFSR_SEED, 5'b00001, LFSR load value at start; must be nonzero.
- GOLDEN, 16'h0000, expected final signature. Overridden at integration.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle run request.
- resp_i  in  2  core response {G23gat, G22gat}.
- pat_o  out  5  pattern {G7gat, G6gat, G3gat, G2gat, G1gat}.
- test_mode_o  out  1  1 = core inputs driven from pat_o.
- busy_o  out  1  run in progress.
- done_o  out  1  run complete; held until the next accepted start.
- pass_o  out  1  signature equals GOLDEN; valid while done_o=1.
- sig_o  out  16  current MISR contents.

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=LFSR_SEED, MISR=0, counter=0. Reset mid-run aborts immediately; no partial result is retained.
- LFSR: Fibonacci, polynomial x^5+x^3+1. next = {q[3:0], q[4]^q[2]}. Period 31. From seed 00001 the sequence is 01, 02, 04, 09, 12, 05, ... (hex).
- MISR: 16-bit, CCITT polynomial. m_next = {m[14:0],0} ^ (m[15] ? 16'h1021 : 0) ^ {14'b0, resp_i}. Updates only on cycles when a capture is valid.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE (also DONE): start_i=1 → RUN. On that edge: LFSR=LFSR_SEED, MISR=0, counter=0, done_o=0, pass_o=0.
- RUN:
  - test_mode_o=1, busy_o=1, pat_o=LFSR.
  - Each cycle the LFSR advances and the counter increments.
  - When counter==N_PAT-1: → DRAIN if RESP_LAT>0, else → DONE.
- Capture timing:
  - A RESP_LAT-deep valid shift register is loaded with 1 on each RUN cycle.
  - The MISR folds resp_i on cycles where the delayed valid bit is 1.
  - With RESP_LAT=0, the fold happens in the same cycle the pattern is driven.
  - Exactly N_PAT folds occur per run.
- DRAIN: test_mode_o=1, busy_o=1, pat_o holds its last value. Lasts RESP_LAT cycles, then → DONE.
- DONE:
  - test_mode_o=0, busy_o=0, done_o=1.
  - pass_o = (final MISR == GOLDEN), registered on entry.
  - sig_o holds the final value.
- pat_o outside RUN/DRAIN: 0.
- Latency: start_i is sampled at edge 0. pat_o is valid for cycles 1..N_PAT. done_o rises at cycle N_PAT+RESP_LAT+1.
- start_i in RUN or DRAIN is ignored; no queueing.
- start_i in DONE restarts the run and clears done_o and pass_o on the same edge.
- Counter width is 10 bits. The LFSR wraps naturally for N_PAT>31, repeating patterns.

Test Plan:
- Reset mid-RUN (RST at cycle 5 of a run) → all outputs 0 in the same cycle, state IDLE, no done_o afterward.
- Defaults, resp_i tied 00, start at cycle 0 → pat_o = 01,02,04,09,12,05,... over cycles 1..31; done_o=1 at cycle 32; sig_o=0000; pass_o=1.
- N_PAT=2, RESP_LAT=0, resp_i=01 constant → sig_o=0003; pass_o=0 with GOLDEN=0; pass_o=1 with GOLDEN=16'h0003.
- RESP_LAT=2, N_PAT=31, bench c17 model delayed 2 cycles → exactly 31 folds; done_o at cycle 34; sig_o equals the bench reference-model MISR; test_mode_o stays high through both DRAIN cycles.
- start_i pulsed at cycles 3 and 10 during RUN → ignored; done_o still rises at cycle 32. start_i in DONE → done_o drops the next cycle and pat_o restarts at 01.
- N_PAT=40 → pattern index 32 equals 01 (LFSR wrap); exactly 40 folds; done_o at cycle 41.
